// File: rtl/decod_bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decod_bcd_pkg
//  Purpose  : Shared constants and types for the BCD-to-binary decoder:
//             FSM state encoding, digit count, largest legal BCD digit,
//             digit-index width and the invalid-digit helper.
//  Revision : 1.0 - initial release
// ============================================================================
package decod_bcd_pkg;

    localparam int         NDIG    = 4;     // digits per conversion
    localparam logic [3:0] DIG_MAX = 4'd9;  // largest legal BCD digit
    localparam int         IDX_W   = 2;     // width of the digit index

    // REPOSO: idle, waiting for inicio. ACUM: one digit accumulated per clock.
    typedef enum logic [0:0] {
        REPOSO = 1'b0,
        ACUM   = 1'b1
    } estado_t;

    // True when a 4-bit code is not a decimal digit (10..15).
    function automatic logic digito_invalido(input logic [3:0] d);
        return (d > DIG_MAX);
    endfunction

endpackage : decod_bcd_pkg
`default_nettype wire

// File: rtl/decod_bcd_bin_mul10_suma.sv
`default_nettype none
// ============================================================================
//  Module   : mul10_suma
//  Purpose  : Combinational acc*10 + digit step of the decimal-to-binary
//             Horner evaluation. The multiply is built from two shifts and
//             an add so no multiplier is inferred. Result wraps modulo
//             2^ANCHO.
//  Ports    : i_acc [ANCHO] running value, i_dig [4] next digit,
//             o_res [ANCHO] i_acc*10 + i_dig
//  Revision : 1.0 - initial release
// ============================================================================
module mul10_suma #(
    parameter int ANCHO = 16
) (
    input  logic [ANCHO-1:0] i_acc,
    input  logic [3:0]       i_dig,
    output logic [ANCHO-1:0] o_res
);

    logic [ANCHO-1:0] w_x8;
    logic [ANCHO-1:0] w_x2;
    logic [ANCHO-1:0] w_dig_ext;

    assign w_x8      = i_acc << 3;
    assign w_x2      = i_acc << 1;
    assign w_dig_ext = {{(ANCHO-4){1'b0}}, i_dig};
    assign o_res     = w_x8 + w_x2 + w_dig_ext;

endmodule : mul10_suma
`default_nettype wire

// File: rtl/decod_bcd_bin.sv
`default_nettype none
// ============================================================================
//  Module   : decod_bcd_bin
//  Purpose  : Sequential BCD-to-binary decoder. Four BCD digits are latched
//             on an accepted inicio, then folded in one per clock as
//             acc = acc*10 + digit (thousands first). The result appears on
//             numero with a one-cycle listo pulse four clocks after the
//             start edge, and is held until the next result.
//  Ports    : clk, rst (sync, active-high)
//             inicio                 start request, sampled only when idle
//             miles/centenas/decenas/unidades [4]  BCD digits
//             numero [ANCHO]         binary result (held)
//             listo                  one-cycle result-valid pulse
//             ocupado                conversion in progress
//             error                  invalid digit seen in last conversion
//  Options  : DECOD_BCD_ERROR_EN - when defined, any digit >9 flags error
//             and forces numero to 0; otherwise error is tied low and
//             digits 10..15 are weighted arithmetically.
//  Revision : 1.0 - initial release
// ============================================================================
module decod_bcd_bin
    import decod_bcd_pkg::*;
#(
    parameter int ANCHO = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [3:0]       miles,
    input  logic [3:0]       centenas,
    input  logic [3:0]       decenas,
    input  logic [3:0]       unidades,
    output logic [ANCHO-1:0] numero,
    output logic             listo,
    output logic             ocupado,
    output logic             error
);

    estado_t            r_estado;
    logic [4*NDIG-1:0]  r_digs;     // {miles, centenas, decenas, unidades}
    logic [ANCHO-1:0]   r_acc;
    logic [IDX_W-1:0]   r_idx;
    logic [ANCHO-1:0]   r_numero;
    logic               r_listo;
    logic               r_ocupado;

    logic [3:0]         w_dig;
    logic [ANCHO-1:0]   w_sig;
    logic               w_ultimo;

    // Digit selected for the current ACUM step; index 0 is the most
    // significant digit so the Horner fold runs thousands -> units.
    always_comb begin
        w_dig = 4'd0;
        case (r_idx)
            2'd0:    w_dig = r_digs[15:12];
            2'd1:    w_dig = r_digs[11:8];
            2'd2:    w_dig = r_digs[7:4];
            default: w_dig = r_digs[3:0];
        endcase
    end

    assign w_ultimo = (r_idx == IDX_W'(NDIG-1));

    mul10_suma #(
        .ANCHO (ANCHO)
    ) u_mul10_suma (
        .i_acc (r_acc),
        .i_dig (w_dig),
        .o_res (w_sig)
    );

`ifdef DECOD_BCD_ERROR_EN
    logic r_err_acc;    // sticky over the ACUM cycles of this conversion
    logic r_error;
    logic w_dig_bad;
    logic w_err_fin;

    assign w_dig_bad = digito_invalido(w_dig);
    assign w_err_fin = r_err_acc | w_dig_bad;
    assign error     = r_error;
`else
    assign error     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado  <= REPOSO;
            r_digs    <= '0;
            r_acc     <= '0;
            r_idx     <= '0;
            r_numero  <= '0;
            r_listo   <= 1'b0;
            r_ocupado <= 1'b0;
`ifdef DECOD_BCD_ERROR_EN
            r_err_acc <= 1'b0;
            r_error   <= 1'b0;
`endif
        end else begin
            case (r_estado)
                REPOSO: begin
                    r_listo <= 1'b0;
                    if (inicio) begin
                        r_digs    <= {miles, centenas, decenas, unidades};
                        r_acc     <= '0;
                        r_idx     <= '0;
                        r_ocupado <= 1'b1;
                        r_estado  <= ACUM;
`ifdef DECOD_BCD_ERROR_EN
                        r_err_acc <= 1'b0;
`endif
                    end
                end

                ACUM: begin
                    // inicio is deliberately not looked at here: a start
                    // request during a conversion is dropped, not queued.
                    r_acc <= w_sig;
                    r_idx <= r_idx + 1'b1;
`ifdef DECOD_BCD_ERROR_EN
                    r_err_acc <= w_err_fin;
`endif
                    if (w_ultimo) begin
`ifdef DECOD_BCD_ERROR_EN
                        r_error  <= w_err_fin;
                        r_numero <= w_err_fin ? '0 : w_sig;
`else
                        r_numero <= w_sig;
`endif
                        r_listo   <= 1'b1;
                        r_ocupado <= 1'b0;
                        r_estado  <= REPOSO;
                    end
                end

                default: r_estado <= REPOSO;
            endcase
        end
    end

    assign numero  = r_numero;
    assign listo   = r_listo;
    assign ocupado = r_ocupado;

endmodule : decod_bcd_bin
`default_nettype wire

// File: tb/tb_decod_bcd_bin.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decod_bcd_bin
//  Purpose  : Directed self-checking bench for decod_bcd_bin (ANCHO=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decod_bcd_bin;

    localparam int ANCHO = 16;

    logic             clk;
    logic             rst;
    logic             inicio;
    logic [3:0]       miles;
    logic [3:0]       centenas;
    logic [3:0]       decenas;
    logic [3:0]       unidades;
    logic [ANCHO-1:0] numero;
    logic             listo;
    logic             ocupado;
    logic             error;

    int checks   = 0;
    int failures = 0;

    decod_bcd_bin #(
        .ANCHO (ANCHO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .inicio   (inicio),
        .miles    (miles),
        .centenas (centenas),
        .decenas  (decenas),
        .unidades (unidades),
        .numero   (numero),
        .listo    (listo),
        .ocupado  (ocupado),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_digs(input logic [3:0] m, c, d, u);
        miles = m; centenas = c; decenas = d; unidades = u;
    endtask

    // Starts a conversion and watches up to 8 edges after the start edge.
    // Returns the edge offset of the first listo (0 if none), the outputs
    // captured there, and how many listo pulses were seen in the window.
    task automatic convert(input logic [3:0] m, c, d, u,
                           output int lat, output logic [ANCHO-1:0] num,
                           output logic err, output int pulses);
        set_digs(m, c, d, u);
        inicio = 1'b1;
        tick();
        inicio = 1'b0;
        lat = 0; num = '0; err = 1'b0; pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (listo) begin
                pulses++;
                if (lat == 0) begin
                    lat = i; num = numero; err = error;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inicio = 1'b1;
        set_digs(4'd1, 4'd2, 4'd3, 4'd4);
        tick();
        tick();
        checks++;
        if ({numero, listo, ocupado, error} !== {16'd0, 3'b000}) begin
            failures++;
            $display("FAIL reset_outputs: numero=%0d listo=%b ocupado=%b error=%b, required 0/0/0/0",
                     numero, listo, ocupado, error);
        end
        rst = 1'b0;
        inicio = 1'b0;
        tick();
        checks++;
        if (ocupado !== 1'b0 || listo !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_start: ocupado=%b listo=%b, required 0/0", ocupado, listo);
        end
    endtask

    task automatic test_latency_1234();
        logic lat_ok;
        set_digs(4'd1, 4'd2, 4'd3, 4'd4);
        inicio = 1'b1;
        tick();                     // edge N
        inicio = 1'b0;
        lat_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin   // after edges N..N+3
            if (ocupado !== 1'b1 || listo !== 1'b0) lat_ok = 1'b0;
            if (i < 3) tick();
        end
        checks++;
        if (!lat_ok) begin
            failures++;
            $display("FAIL latency_busy: ocupado/listo wrong during N..N+3, last ocupado=%b listo=%b, required 1/0",
                     ocupado, listo);
        end
        tick();                     // edge N+4
        checks++;
        if (listo !== 1'b1 || ocupado !== 1'b0 || numero !== 16'h04D2) begin
            failures++;
            $display("FAIL result_1234: listo=%b ocupado=%b numero=%0d, required 1/0/1234",
                     listo, ocupado, numero);
        end
        tick();                     // edge N+5
        checks++;
        if (listo !== 1'b0 || numero !== 16'h04D2) begin
            failures++;
            $display("FAIL listo_one_cycle: listo=%b numero=%0d, required 0/1234", listo, numero);
        end
    endtask

    task automatic test_extremes();
        int lat, pulses;
        logic [ANCHO-1:0] num;
        logic err;
        convert(4'd9, 4'd9, 4'd9, 4'd9, lat, num, err, pulses);
        checks++;
        if (lat !== 4 || num !== 16'h270F || pulses !== 1) begin
            failures++;
            $display("FAIL result_9999: lat=%0d numero=%0d pulses=%0d, required 4/9999/1", lat, num, pulses);
        end
        convert(4'd0, 4'd0, 4'd0, 4'd0, lat, num, err, pulses);
        checks++;
        if (lat !== 4 || num !== 16'd0 || pulses !== 1) begin
            failures++;
            $display("FAIL result_0000: lat=%0d numero=%0d pulses=%0d, required 4/0/1", lat, num, pulses);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        set_digs(4'd5, 4'd0, 4'd0, 4'd7);
        inicio = 1'b1;
        tick();                     // edge N: accepted
        inicio = 1'b0;
        pulses = 0;
        tick();                     // N+1
        set_digs(4'd8, 4'd8, 4'd8, 4'd8);
        inicio = 1'b1;              // sampled at N+2 while busy: ignored
        if (listo) pulses++;
        tick();                     // N+2
        inicio = 1'b0;
        if (listo) pulses++;
        tick();                     // N+3
        if (listo) pulses++;
        tick();                     // N+4
        checks++;
        if (listo !== 1'b1 || numero !== 16'd5007 || pulses !== 0) begin
            failures++;
            $display("FAIL ignore_busy_start: listo=%b numero=%0d early_pulses=%0d, required 1/5007/0",
                     listo, numero, pulses);
        end
        set_digs(4'd0, 4'd0, 4'd4, 4'd2);
        inicio = 1'b1;
        tick();                     // N+5: accepted in the listo cycle
        inicio = 1'b0;
        checks++;
        if (listo !== 1'b0 || ocupado !== 1'b1 || numero !== 16'd5007) begin
            failures++;
            $display("FAIL b2b_accept: listo=%b ocupado=%b numero=%0d, required 0/1/5007",
                     listo, ocupado, numero);
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();                 // N+6..N+8
            if (listo) pulses++;
        end
        tick();                     // N+9
        checks++;
        if (listo !== 1'b1 || numero !== 16'd42 || pulses !== 0) begin
            failures++;
            $display("FAIL b2b_result: listo=%b numero=%0d early_pulses=%0d, required 1/42/0",
                     listo, numero, pulses);
        end
    endtask

    task automatic test_invalid_digit();
        int lat, pulses;
        logic [ANCHO-1:0] num;
        logic err;
        convert(4'd1, 4'd0, 4'hA, 4'd0, lat, num, err, pulses);
        checks++;
`ifdef DECOD_BCD_ERROR_EN
        if (lat !== 4 || num !== 16'd0 || err !== 1'b1) begin
            failures++;
            $display("FAIL invalid_10A0: lat=%0d numero=%0d error=%b, required 4/0/1", lat, num, err);
        end
`else
        if (lat !== 4 || num !== 16'd1100 || err !== 1'b0) begin
            failures++;
            $display("FAIL invalid_10A0: lat=%0d numero=%0d error=%b, required 4/1100/0", lat, num, err);
        end
`endif
        convert(4'd0, 4'd0, 4'd1, 4'd2, lat, num, err, pulses);
        checks++;
        if (lat !== 4 || num !== 16'd12 || err !== 1'b0) begin
            failures++;
            $display("FAIL after_invalid_0012: lat=%0d numero=%0d error=%b, required 4/12/0", lat, num, err);
        end
    endtask

    task automatic test_reset_mid();
        int lat, pulses;
        logic [ANCHO-1:0] num;
        logic err;
        set_digs(4'd3, 4'd3, 4'd3, 4'd3);
        inicio = 1'b1;
        tick();                     // N
        inicio = 1'b0;
        tick();                     // N+1
        rst = 1'b1;
        tick();                     // N+2: reset
        rst = 1'b0;
        checks++;
        if (numero !== 16'd0 || ocupado !== 1'b0 || listo !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: numero=%0d ocupado=%b listo=%b, required 0/0/0",
                     numero, ocupado, listo);
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (listo) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_listo: pulses=%0d, required 0", pulses);
        end
        convert(4'd3, 4'd3, 4'd3, 4'd3, lat, num, err, pulses);
        checks++;
        if (lat !== 4 || num !== 16'd3333 || pulses !== 1) begin
            failures++;
            $display("FAIL after_reset_3333: lat=%0d numero=%0d pulses=%0d, required 4/3333/1", lat, num, pulses);
        end
    endtask

    initial begin
        rst = 1'b1;
        inicio = 1'b0;
        set_digs(4'd0, 4'd0, 4'd0, 4'd0);
        test_reset();
        test_latency_1234();
        test_extremes();
        test_back_to_back();
        test_invalid_digit();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_decod_bcd_bin
`default_nettype wire
